// File: rtl/cpu_pkg.sv
// Shared width constants for the 32-bit pipelined CPU datapath.
package cpu_pkg;

    localparam int DATA_W   = 32;
    localparam int ALU_W    = 6;
    localparam int RADDR_W  = 4;
    localparam int BANK_W   = 2;
    localparam int ALU_OP_W = ALU_W;

endpackage : cpu_pkg

// File: rtl/id_ex_register.sv
// ID/EX pipeline register: captures decode fields each edge, holds on stall.
// Optional bubble insert via flush port when ID_EX_FLUSH_EN is defined.
module id_ex_register
    import cpu_pkg::*;
#(
    parameter int P_DATA_W  = DATA_W,
    parameter int P_ALU_W   = ALU_OP_W,
    parameter int P_RADDR_W = RADDR_W,
    parameter int P_BANK_W  = BANK_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
`ifdef ID_EX_FLUSH_EN
    input  logic                 flush,
`endif
    input  logic                 mux4_in,
    input  logic                 data_mem_in,
    input  logic [P_ALU_W-1:0]   alu_in,
    input  logic [P_DATA_W-1:0]  regA_in,
    input  logic [P_DATA_W-1:0]  regB_in,
    input  logic [P_BANK_W-1:0]  regs_bank_in,
    input  logic [P_DATA_W-1:0]  pc_in,
    input  logic [P_RADDR_W-1:0] regC_adress_in,
    input  logic                 write_inst_in,
    output logic                 mux4_out,
    output logic                 data_mem_out,
    output logic [P_ALU_W-1:0]   alu_out,
    output logic [P_DATA_W-1:0]  regA_out,
    output logic [P_DATA_W-1:0]  regB_out,
    output logic [P_BANK_W-1:0]  regs_bank_out,
    output logic [P_DATA_W-1:0]  pc_out,
    output logic [P_RADDR_W-1:0] regC_adress_out,
    output logic                 write_inst_out
);

    logic w_flush;

`ifdef ID_EX_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // Outputs are the flops themselves; a bubble is an all-zero control word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux4_out        <= 1'b0;
            data_mem_out    <= 1'b0;
            alu_out         <= '0;
            regA_out        <= '0;
            regB_out        <= '0;
            regs_bank_out   <= '0;
            pc_out          <= '0;
            regC_adress_out <= '0;
            write_inst_out  <= 1'b0;
        end else if (w_flush) begin
            mux4_out        <= 1'b0;
            data_mem_out    <= 1'b0;
            alu_out         <= '0;
            regA_out        <= '0;
            regB_out        <= '0;
            regs_bank_out   <= '0;
            pc_out          <= '0;
            regC_adress_out <= '0;
            write_inst_out  <= 1'b0;
        end else if (!stall) begin
            mux4_out        <= mux4_in;
            data_mem_out    <= data_mem_in;
            alu_out         <= alu_in;
            regA_out        <= regA_in;
            regB_out        <= regB_in;
            regs_bank_out   <= regs_bank_in;
            pc_out          <= pc_in;
            regC_adress_out <= regC_adress_in;
            write_inst_out  <= write_inst_in;
        end
    end

endmodule : id_ex_register

// File: tb/tb_id_ex_register.sv
// Directed self-checking bench for id_ex_register.
module tb_id_ex_register;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        mux4_in, data_mem_in, write_inst_in;
    logic [5:0]  alu_in;
    logic [31:0] regA_in, regB_in, pc_in;
    logic [1:0]  regs_bank_in;
    logic [3:0]  regC_adress_in;
    logic        mux4_out, data_mem_out, write_inst_out;
    logic [5:0]  alu_out;
    logic [31:0] regA_out, regB_out, pc_out;
    logic [1:0]  regs_bank_out;
    logic [3:0]  regC_adress_out;

    int checks = 0;
    int errors = 0;

    logic [110:0] obs;
    logic [110:0] exp_v;

    localparam logic [110:0] V0 = '0;
    localparam logic [110:0] V1 = {1'b1, 1'b0, 6'd25, 32'd100, 32'd240, 2'd2, 32'd620, 4'd9, 1'b1};
    localparam logic [110:0] V2 = {1'b0, 1'b1, 6'd20, 32'd450, 32'd170, 2'd3, 32'd380, 4'd6, 1'b0};
    localparam logic [110:0] V3 = {1'b1, 1'b1, 6'd63, 32'hDEADBEEF, 32'h12345678, 2'd1, 32'hFFFFFFFC, 4'd15, 1'b1};

    assign obs = {mux4_out, data_mem_out, alu_out, regA_out, regB_out,
                  regs_bank_out, pc_out, regC_adress_out, write_inst_out};

    id_ex_register dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
`ifdef ID_EX_FLUSH_EN
        .flush           (flush),
`endif
        .mux4_in         (mux4_in),
        .data_mem_in     (data_mem_in),
        .alu_in          (alu_in),
        .regA_in         (regA_in),
        .regB_in         (regB_in),
        .regs_bank_in    (regs_bank_in),
        .pc_in           (pc_in),
        .regC_adress_in  (regC_adress_in),
        .write_inst_in   (write_inst_in),
        .mux4_out        (mux4_out),
        .data_mem_out    (data_mem_out),
        .alu_out         (alu_out),
        .regA_out        (regA_out),
        .regB_out        (regB_out),
        .regs_bank_out   (regs_bank_out),
        .pc_out          (pc_out),
        .regC_adress_out (regC_adress_out),
        .write_inst_out  (write_inst_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [110:0] v);
        {mux4_in, data_mem_in, alu_in, regA_in, regB_in,
         regs_bank_in, pc_in, regC_adress_in, write_inst_in} = v;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive(V3);
        #3;
        checks++;
        if (obs !== V0) begin
            errors++;
            $display("FAIL reset_no_edge got %h exp %h", obs, V0);
        end
        @(posedge clk); #1;
        checks++;
        if (obs !== V0) begin
            errors++;
            $display("FAIL reset_held_edge got %h exp %h", obs, V0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load;
        drive(V1);
        #2;
        checks++;
        if (obs !== V0) begin
            errors++;
            $display("FAIL load_before_edge got %h exp %h", obs, V0);
        end
        @(posedge clk); #1;
        checks++;
        if (obs !== V1) begin
            errors++;
            $display("FAIL load_after_edge got %h exp %h", obs, V1);
        end
    endtask

    task automatic test_update;
        @(negedge clk);
        drive(V2);
        #2;
        checks++;
        if (obs !== V1) begin
            errors++;
            $display("FAIL update_before_edge got %h exp %h", obs, V1);
        end
        @(posedge clk); #1;
        checks++;
        if (obs !== V2) begin
            errors++;
            $display("FAIL update_after_edge got %h exp %h", obs, V2);
        end
        // Input wiggle between edges must not reach the outputs.
        drive(V1);
        #2;
        drive(V2);
        #1;
        checks++;
        if (obs !== V2) begin
            errors++;
            $display("FAIL between_edges got %h exp %h", obs, V2);
        end
    endtask

    task automatic test_stall;
        @(negedge clk);
        stall = 1'b1;
        drive(V3);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (obs !== V2) begin
                errors++;
                $display("FAIL stall_hold_%0d got %h exp %h", i, obs, V2);
            end
        end
        @(negedge clk);
        stall = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (obs !== V3) begin
            errors++;
            $display("FAIL stall_release got %h exp %h", obs, V3);
        end
    endtask

`ifdef ID_EX_FLUSH_EN
    task automatic test_flush;
        @(negedge clk);
        stall = 1'b1;
        flush = 1'b1;
        drive(V1);
        @(posedge clk); #1;
        checks++;
        if (obs !== V0) begin
            errors++;
            $display("FAIL flush_over_stall got %h exp %h", obs, V0);
        end
        @(negedge clk);
        flush = 1'b0;
        stall = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (obs !== V1) begin
            errors++;
            $display("FAIL flush_resume got %h exp %h", obs, V1);
        end
    endtask
`endif

    task automatic test_midrun_reset;
        @(negedge clk);
        drive(V2);
        @(posedge clk); #1;
        checks++;
        if (obs !== V2) begin
            errors++;
            $display("FAIL pre_reset_load got %h exp %h", obs, V2);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== V0) begin
            errors++;
            $display("FAIL midrun_reset_async got %h exp %h", obs, V0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(V3);
        #1;
        checks++;
        if (obs !== V0) begin
            errors++;
            $display("FAIL reset_release_no_edge got %h exp %h", obs, V0);
        end
        @(posedge clk); #1;
        checks++;
        if (obs !== V3) begin
            errors++;
            $display("FAIL reload_after_reset got %h exp %h", obs, V3);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_update();
        test_stall();
`ifdef ID_EX_FLUSH_EN
        test_flush();
`endif
        test_midrun_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

endmodule : tb_id_ex_register
